cpu_wr_logger: RTL

- Memory-mapped trace peripheral on the sigma host bus at base 0x00100000.
- Snoops committed CPU data-bus writes and filters them by address match.
- Timestamps each matching write and stores address, data and timestamp in an on-chip FIFO.
- The UDM debug host (or the CPU) configures the block, then drains the FIFO through read-only window registers.

---
 rtl/cpu_wr_logger.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/cpu_wr_logger.sv
// Trace peripheral: snoops committed CPU writes, filters them by address, and queues
// {addr, data, timestamp} entries that a bus master drains through window registers.
module cpu_wr_logger #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned TS_W  = 32
) (
    input  logic        clk_i,
    input  logic        arst_i,
    input  logic        bus_req_i,
    input  logic        bus_we_i,
    input  logic [7:0]  bus_addr_i,
    input  logic [31:0] bus_wdata_i,
    output logic        bus_ack_o,
    output logic        bus_resp_o,
    output logic [31:0] bus_rdata_o,
    input  logic        snp_valid_i,
    input  logic [31:0] snp_addr_i,
    input  logic [31:0] snp_wdata_i,
    output logic        irq_o
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    localparam logic [5:0] OffFiltBase = 6'h01;
    localparam logic [5:0] OffFiltMask = 6'h02;
    localparam logic [5:0] OffCtrl     = 6'h0B;
    localparam logic [5:0] OffStatus   = 6'h0C;
    localparam logic [5:0] OffDrop     = 6'h0D;
    localparam logic [5:0] OffClr      = 6'h13;
    localparam logic [5:0] OffHeadAddr = 6'h14;
    localparam logic [5:0] OffHeadData = 6'h15;
    localparam logic [5:0] OffHeadTs   = 6'h16;
    localparam logic [5:0] OffPop      = 6'h17;

    logic [31:0]   r_filt_base;
    logic [31:0]   r_filt_mask;
    logic [7:0]    r_ctrl;
    logic [TS_W-1:0] r_ts;
    logic [31:0]   r_drop;
    logic          r_ovf;
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_resp;
    logic [31:0]   r_rdata;
    logic          r_irq;

    logic [31:0]     r_mem_addr [DEPTH];
    logic [31:0]     r_mem_data [DEPTH];
    logic [TS_W-1:0] r_mem_ts   [DEPTH];

    logic [5:0]  w_off;
    logic [1:0]  w_unused_addr;
    logic        w_acc_wr;
    logic        w_acc_rd;
    logic        w_clr;
    logic        w_empty;
    logic        w_full;
    logic        w_pop;
    logic        w_match;
    logic        w_push;
    logic        w_drop;
    logic [31:0] w_rdata;

    assign w_off         = bus_addr_i[7:2];
    assign w_unused_addr = bus_addr_i[1:0];
    assign w_acc_wr      = bus_req_i & bus_we_i;
    assign w_acc_rd      = bus_req_i & ~bus_we_i;
    assign w_clr         = w_acc_wr & (w_off == OffClr);
    assign w_empty       = (r_count == '0);
    assign w_full        = (r_count == CW'(DEPTH));
    assign w_pop         = w_acc_rd & (w_off == OffPop) & ~w_empty;
    assign w_match       = snp_valid_i & r_ctrl[0] &
                           ((snp_addr_i & r_filt_mask) == (r_filt_base & r_filt_mask));
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign w_push        = w_match & ~w_clr & (~w_full | w_pop);
    assign w_drop        = w_match & ~w_clr & w_full & ~w_pop;

    assign bus_ack_o   = bus_req_i;
    assign bus_resp_o  = r_resp;
    assign bus_rdata_o = r_rdata;
    assign irq_o       = r_irq;

    always_comb begin
        w_rdata = '0;
        case (w_off)
            OffFiltBase: w_rdata = r_filt_base;
            OffFiltMask: w_rdata = r_filt_mask;
            OffCtrl:     w_rdata = {24'd0, r_ctrl};
            OffStatus:   w_rdata = {21'd0, r_ovf, w_empty, w_full, 1'b0, 7'(r_count)};
            OffDrop:     w_rdata = r_drop;
            OffHeadAddr: w_rdata = w_empty ? '0 : r_mem_addr[r_rptr];
            OffHeadData: w_rdata = w_empty ? '0 : r_mem_data[r_rptr];
            OffHeadTs:   w_rdata = w_empty ? '0 : 32'(r_mem_ts[r_rptr]);
            OffPop:      w_rdata = 32'(r_count);
            default:     w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_i) begin
        if (!arst_i) begin
            r_filt_base <= '0;
            r_filt_mask <= '0;
            r_ctrl      <= '0;
            r_ts        <= '0;
            r_drop      <= '0;
            r_ovf       <= 1'b0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_resp      <= 1'b0;
            r_rdata     <= '0;
            r_irq       <= 1'b0;
        end else begin
            r_resp  <= w_acc_rd;
            r_rdata <= w_acc_rd ? w_rdata : '0;
            r_irq   <= (8'(r_count) >= {1'b0, r_ctrl[7:1]}) & (r_ctrl[7:1] != 7'd0);

            if (w_acc_wr) begin
                case (w_off)
                    OffFiltBase: r_filt_base <= bus_wdata_i;
                    OffFiltMask: r_filt_mask <= bus_wdata_i;
                    OffCtrl:     r_ctrl      <= bus_wdata_i[7:0];
                    default:     ;
                endcase
            end

            if (w_clr) begin
                r_ts    <= '0;
                r_drop  <= '0;
                r_ovf   <= 1'b0;
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else begin
                if (r_ctrl[0]) begin
                    r_ts <= r_ts + 1'b1;
                end
                if (w_push) begin
                    r_wptr <= r_wptr + 1'b1;
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + 1'b1;
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + 1'b1;
                end else if (w_pop && !w_push) begin
                    r_count <= r_count - 1'b1;
                end
                if (w_drop) begin
                    r_ovf <= 1'b1;
                    if (r_drop != '1) begin
                        r_drop <= r_drop + 1'b1;
                    end
                end
            end
        end
    end

    // Storage needs no reset: the head window is gated by EMPTY.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem_addr[r_wptr] <= snp_addr_i;
            r_mem_data[r_wptr] <= snp_wdata_i;
            r_mem_ts[r_wptr]   <= r_ts;
        end
    end
endmodule
